program_memory_loader: RTL and testbench
========================================

// Module: program_memory_loader
// PURPOSE
//  Program-memory side of the instruction fetch interface, the responder to the core's PC/fetch path.
//  Loads a program from an external byte stream: a valid/ready handshake, instruction byte first, then argument byte.
//  Each byte pair is stored as one INSTRUCTION_WIDTH word.
//  Holds the core in reset while loading. Once loading completes, it answers fetches with the split INSTR/ARG bytes.
// PARAMETERS
//  DATA_WIDTH        8   width of one stream byte, INSTR_OUT and ARG_OUT
//  ADDR_WIDTH        12  word address width; memory depth = 2**ADDR_WIDTH words
//  INSTRUCTION_WIDTH 16  stored word width; must equal 2*DATA_WIDTH
// PORTS
//  clk         in   1           single clock, rising edge
//  reset       in   1           asynchronous, active-low reset
//  LOAD_START  in   1           pulse: begin (re)load at word address 0
//  LOAD_END    in   1           pulse: end of program stream
//  LOAD_VALID  in   1           LOAD_DATA valid
//  LOAD_DATA   in   DATA_WIDTH  stream byte
//  LOAD_READY  out  1           block accepts LOAD_DATA this cycle
//  FETCH_REQ   in   1           fetch request from core
//  FETCH_ADDR  in   ADDR_WIDTH  word address (core PC)
//  FETCH_VALID out  1           INSTR_OUT/ARG_OUT valid
//  INSTR_OUT   out  DATA_WIDTH  upper byte of fetched word
//  ARG_OUT     out  DATA_WIDTH  lower byte of fetched word
//  CPU_HOLD    out  1           1 = hold core in reset
//  LOAD_COUNT  out  ADDR_WIDTH+1 number of words loaded
//  LOAD_ERR    out  1           sticky: odd byte count at LOAD_END
// BEHAVIOUR
//  Reset (async, reset=0):
//   - state IDLE, CPU_HOLD=1; all other outputs 0; write pointer 0.
//   - Memory contents are not cleared.
//  FSM states: IDLE, LOAD_HI, LOAD_LO, WRITE, RUN.
//  IDLE:
//   - LOAD_READY=0; fetches are ignored.
//   - LOAD_START -> LOAD_HI; pointer=0, LOAD_COUNT=0, LOAD_ERR=0.
//  LOAD_HI:
//   - LOAD_READY = ~LOAD_END.
//   - On VALID&READY: latch hi byte -> LOAD_LO.
//   - LOAD_END -> RUN. LOAD_END wins over a simultaneous VALID; that byte is not accepted.
//  LOAD_LO:
//   - LOAD_READY = ~LOAD_END.
//   - On VALID&READY: latch lo byte -> WRITE.
//   - LOAD_END -> LOAD_ERR=1, discard the hi byte, -> RUN.
//  WRITE (1 cycle):
//   - LOAD_READY=0; mem[ptr] <= {hi,lo}; ptr++; LOAD_COUNT++.
//   - If ptr was 2**ADDR_WIDTH-1 (memory full): LOAD_COUNT = 2**ADDR_WIDTH, pointer wraps to 0, -> RUN.
//   - Otherwise -> LOAD_HI.
//   - Throughput: 2 bytes per 3 cycles at best.
//  RUN:
//   - CPU_HOLD=0, registered; it falls the cycle after RUN is entered.
//   - FETCH_REQ in cycle N -> FETCH_VALID=1 in cycle N+1 (1-cycle latency).
//   - Data: INSTR_OUT=mem[FETCH_ADDR][2*DW-1:DW], ARG_OUT=mem[FETCH_ADDR][DW-1:0].
//   - If FETCH_ADDR >= LOAD_COUNT: return INSTR_OUT=0, ARG_OUT=0 (NOP), FETCH_VALID still 1.
//   - With no FETCH_REQ: FETCH_VALID=0 next cycle; INSTR_OUT/ARG_OUT hold their last values.
//   - Back-to-back requests are served every cycle.
//   - LOAD_START in RUN -> LOAD_HI; CPU_HOLD=1 the next cycle; count/err cleared; FETCH_VALID=0.
//  Global rules:
//   - LOAD_START in LOAD_HI/LOAD_LO/WRITE restarts at address 0; a partial byte is dropped, no error.
//   - FETCH_REQ outside RUN: ignored, FETCH_VALID stays 0.
//   - Reset asserted mid-load: immediate return to IDLE, CPU_HOLD=1; words already written remain.
// TESTING
//  1 Reset, LOAD_START, stream 0x12,0x34,0x56,0x78, LOAD_END
//    -> LOAD_COUNT=2, LOAD_ERR=0, CPU_HOLD=0.
//    -> FETCH_ADDR=1 gives INSTR=0x56, ARG=0x78, 1 cycle later.
//  2 Stream 3 bytes 0xAA,0xBB,0xCC then LOAD_END
//    -> LOAD_ERR=1, LOAD_COUNT=1.
//    -> fetch addr 1 returns 0x00/0x00; fetch addr 0 returns 0xAA/0xBB.
//  3 LOAD_VALID held high continuously
//    -> LOAD_READY pattern 1,1,0 repeating; no byte lost or duplicated.
//    -> LOAD_END together with VALID in LOAD_HI: that byte is not written.
//  4 ADDR_WIDTH=2, stream 10 bytes
//    -> RUN entered after 8 bytes, LOAD_COUNT=4; LOAD_READY=0 afterwards.
//  5 In RUN, FETCH_REQ every cycle for addr 0,1,2,3
//    -> FETCH_VALID high 4 cycles, data in order.
//    -> LOAD_START mid-burst: CPU_HOLD=1 next cycle, FETCH_VALID=0.
//  6 Assert reset after 1 word loaded
//    -> IDLE, CPU_HOLD=1, LOAD_COUNT=0.
//    -> reload 1 new word and fetch addr 0 -> new data.

Source files
------------

// File: rtl/program_memory_loader_if.sv
// ============================================================================
// program_memory_loader_if
// Load-stream, fetch-port and status signals between the loader and the core.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface program_memory_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
);
  logic                  load_start;
  logic                  load_end;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_ready;
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_valid;
  logic [DATA_WIDTH-1:0] instr_out;
  logic [DATA_WIDTH-1:0] arg_out;
  logic                  cpu_hold;
  logic [ADDR_WIDTH:0]   load_count;
  logic                  load_err;

  // Stream source / core side
  modport master (
    output load_start, load_end, load_valid, load_data, fetch_req, fetch_addr,
    input  load_ready, fetch_valid, instr_out, arg_out, cpu_hold, load_count, load_err
  );

  // Loader side
  modport slave (
    input  load_start, load_end, load_valid, load_data, fetch_req, fetch_addr,
    output load_ready, fetch_valid, instr_out, arg_out, cpu_hold, load_count, load_err
  );
endinterface

`default_nettype wire

// File: rtl/program_memory_loader.sv
// ============================================================================
// program_memory_loader
// Loads byte-pair program words from a stream, holds the core, then serves fetches.
// Revision: 1.0
// ============================================================================
`default_nettype none

module program_memory_loader #(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 12,
  parameter int INSTRUCTION_WIDTH = 16   // must equal 2*DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  program_memory_loader_if.slave   bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_HI = 3'd1;
  localparam logic [2:0] S_LOAD_LO = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [2:0]                   state;
  logic [ADDR_WIDTH-1:0]        wr_ptr;
  logic [DATA_WIDTH-1:0]        hi_byte;
  logic [DATA_WIDTH-1:0]        lo_byte;
  logic [ADDR_WIDTH:0]          load_count;
  logic                         load_err;
  logic                         cpu_hold;
  logic                         fetch_valid;
  logic [DATA_WIDTH-1:0]        instr_out;
  logic [DATA_WIDTH-1:0]        arg_out;

  logic [INSTRUCTION_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [INSTRUCTION_WIDTH-1:0] rd_word;
  logic                         in_range;

  assign rd_word  = mem[bus.fetch_addr];
  assign in_range = ({1'b0, bus.fetch_addr} < load_count);

  // LOAD_END blocks acceptance so a coincident byte is never half-taken
  assign bus.load_ready  = ((state == S_LOAD_HI) || (state == S_LOAD_LO)) && !bus.load_end;
  assign bus.fetch_valid = fetch_valid;
  assign bus.instr_out   = instr_out;
  assign bus.arg_out     = arg_out;
  assign bus.cpu_hold    = cpu_hold;
  assign bus.load_count  = load_count;
  assign bus.load_err    = load_err;

  // Memory has no reset so a reset mid-load keeps already written words
  always_ff @(posedge clk) begin
    if (state == S_WRITE && !bus.load_start) begin
      mem[wr_ptr] <= {hi_byte, lo_byte};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      hi_byte     <= '0;
      lo_byte     <= '0;
      load_count  <= '0;
      load_err    <= 1'b0;
      cpu_hold    <= 1'b1;
      fetch_valid <= 1'b0;
      instr_out   <= '0;
      arg_out     <= '0;
    end else begin
      fetch_valid <= 1'b0;
      if (bus.load_start) begin
        state      <= S_LOAD_HI;
        wr_ptr     <= '0;
        load_count <= '0;
        load_err   <= 1'b0;
        cpu_hold   <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_IDLE;
          end
          S_LOAD_HI: begin
            if (bus.load_end) begin
              state <= S_RUN;
            end else if (bus.load_valid) begin
              hi_byte <= bus.load_data;
              state   <= S_LOAD_LO;
            end
          end
          S_LOAD_LO: begin
            if (bus.load_end) begin
              load_err <= 1'b1;
              state    <= S_RUN;
            end else if (bus.load_valid) begin
              lo_byte <= bus.load_data;
              state   <= S_WRITE;
            end
          end
          S_WRITE: begin
            wr_ptr     <= wr_ptr + PTR_ONE;
            load_count <= load_count + CNT_ONE;
            state      <= (wr_ptr == {ADDR_WIDTH{1'b1}}) ? S_RUN : S_LOAD_HI;
          end
          S_RUN: begin
            cpu_hold    <= 1'b0;
            fetch_valid <= bus.fetch_req;
            if (bus.fetch_req) begin
              instr_out <= in_range ? rd_word[INSTRUCTION_WIDTH-1:DATA_WIDTH] : '0;
              arg_out   <= in_range ? rd_word[DATA_WIDTH-1:0] : '0;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_program_memory_loader.sv
// ============================================================================
// tb_program_memory_loader
// Directed, table-driven bench for the program memory loader (4-word memory).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_program_memory_loader;

  localparam int DW = 8;
  localparam int AW = 2;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] instr;
    logic [DW-1:0] arg;
  } fvec_t;

  logic  clk = 1'b0;
  logic  reset = 1'b0;
  int    total_cnt = 0;
  int    pass_cnt  = 0;
  fvec_t fv [0:7];

  program_memory_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  program_memory_loader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INSTRUCTION_WIDTH(2*DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [DW-1:0] b);
    int n = 0;
    bus.load_valid = 1'b1;
    bus.load_data  = b;
    while (!bus.load_ready && n < 10) begin tick(); n++; end
    check("send_ready", 16'(bus.load_ready), 16'd1);
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic end_stream();
    int n = 0;
    while (!bus.load_ready && n < 10) begin tick(); n++; end
    check("end_ready", 16'(bus.load_ready), 16'd1);
    bus.load_end = 1'b1;
    tick();
    bus.load_end = 1'b0;
    check("hold_in_first_run_cycle", 16'(bus.cpu_hold), 16'd1);
    tick();
    check("hold_released", 16'(bus.cpu_hold), 16'd0);
  endtask

  // Applies fv[0..n-1] back-to-back, then one idle cycle
  task automatic run_fetch(input int n);
    for (int i = 0; i < n; i++) begin
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = fv[i].addr;
      tick();
      check("fetch_valid", 16'(bus.fetch_valid), 16'd1);
      check("fetch_instr", 16'(bus.instr_out), 16'(fv[i].instr));
      check("fetch_arg",   16'(bus.arg_out),   16'(fv[i].arg));
    end
    bus.fetch_req = 1'b0;
    tick();
    check("idle_valid",      16'(bus.fetch_valid), 16'd0);
    check("idle_hold_instr", 16'(bus.instr_out), 16'(fv[n-1].instr));
    check("idle_hold_arg",   16'(bus.arg_out),   16'(fv[n-1].arg));
  endtask

  initial begin
    int k;
    logic rdy;
    bus.load_start = 1'b0; bus.load_end = 1'b0; bus.load_valid = 1'b0;
    bus.load_data  = '0;   bus.fetch_req = 1'b0; bus.fetch_addr = '0;

    // Reset state
    repeat (3) tick();
    check("rst_hold",  16'(bus.cpu_hold),    16'd1);
    check("rst_count", 16'(bus.load_count),  16'd0);
    check("rst_err",   16'(bus.load_err),    16'd0);
    check("rst_ready", 16'(bus.load_ready),  16'd0);
    check("rst_valid", 16'(bus.fetch_valid), 16'd0);
    check("rst_instr", 16'(bus.instr_out),   16'd0);
    check("rst_arg",   16'(bus.arg_out),     16'd0);
    reset = 1'b1;
    tick();
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    check("idle_fetch_ignored", 16'(bus.fetch_valid), 16'd0);

    // Two-word program
    pulse_start();
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    end_stream();
    check("t1_count", 16'(bus.load_count), 16'd2);
    check("t1_err",   16'(bus.load_err),   16'd0);
    fv[0] = '{2'd1, 8'h56, 8'h78};
    fv[1] = '{2'd0, 8'h12, 8'h34};
    fv[2] = '{2'd2, 8'h00, 8'h00};
    fv[3] = '{2'd3, 8'h00, 8'h00};
    run_fetch(4);

    // Odd byte count
    pulse_start();
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    end_stream();
    check("t2_err",   16'(bus.load_err),   16'd1);
    check("t2_count", 16'(bus.load_count), 16'd1);
    fv[0] = '{2'd1, 8'h00, 8'h00};
    fv[1] = '{2'd0, 8'hAA, 8'hBB};
    run_fetch(2);

    // Continuous VALID: READY 1,1,0 and END beats a coincident byte
    pulse_start();
    k = 0;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hA0;
    for (int c = 0; c < 6; c++) begin
      rdy = bus.load_ready;
      check("t3_ready_pattern", 16'(rdy), ((c % 3) != 2) ? 16'd1 : 16'd0);
      tick();
      if (rdy) begin k++; bus.load_data = 8'hA0 + 8'(k); end
    end
    bus.load_end = 1'b1;
    #1;
    check("t3_ready_during_end", 16'(bus.load_ready), 16'd0);
    tick();
    bus.load_end = 1'b0; bus.load_valid = 1'b0;
    tick();
    check("t3_count", 16'(bus.load_count), 16'd2);
    check("t3_err",   16'(bus.load_err),   16'd0);
    check("t3_hold",  16'(bus.cpu_hold),   16'd0);
    fv[0] = '{2'd0, 8'hA0, 8'hA1};
    fv[1] = '{2'd1, 8'hA2, 8'hA3};
    fv[2] = '{2'd2, 8'h00, 8'h00};
    run_fetch(3);

    // Memory full after 8 bytes
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(8'h30 + 8'(i));
    tick();
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h38;
    for (int c = 0; c < 3; c++) begin
      check("t4_ready_after_full", 16'(bus.load_ready), 16'd0);
      tick();
    end
    bus.load_valid = 1'b0;
    check("t4_count", 16'(bus.load_count), 16'd4);
    check("t4_err",   16'(bus.load_err),   16'd0);
    check("t4_hold",  16'(bus.cpu_hold),   16'd0);

    // Back-to-back burst, then LOAD_START mid-burst
    fv[0] = '{2'd0, 8'h30, 8'h31};
    fv[1] = '{2'd1, 8'h32, 8'h33};
    fv[2] = '{2'd2, 8'h34, 8'h35};
    fv[3] = '{2'd3, 8'h36, 8'h37};
    run_fetch(4);
    bus.fetch_req = 1'b1; bus.fetch_addr = 2'd2;
    tick();
    check("t5_pre_valid", 16'(bus.fetch_valid), 16'd1);
    check("t5_pre_instr", 16'(bus.instr_out),   16'h34);
    bus.fetch_addr = 2'd3; bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0; bus.fetch_req = 1'b0;
    check("t5_valid_after_start", 16'(bus.fetch_valid), 16'd0);
    check("t5_hold_after_start",  16'(bus.cpu_hold),    16'd1);
    check("t5_count_cleared",     16'(bus.load_count),  16'd0);

    // Reset after one word, then reload
    send_byte(8'h5A); send_byte(8'hA5);
    tick();
    check("t6_count_before_rst", 16'(bus.load_count), 16'd1);
    reset = 1'b0;
    #1;
    check("t6_rst_hold",  16'(bus.cpu_hold),   16'd1);
    check("t6_rst_count", 16'(bus.load_count), 16'd0);
    check("t6_rst_ready", 16'(bus.load_ready), 16'd0);
    tick();
    reset = 1'b1;
    tick();
    pulse_start();
    send_byte(8'hC3); send_byte(8'h3C);
    end_stream();
    check("t6_count", 16'(bus.load_count), 16'd1);
    fv[0] = '{2'd0, 8'hC3, 8'h3C};
    fv[1] = '{2'd1, 8'h00, 8'h00};
    run_fetch(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
